// File: rtl/jesd204_soft_pcs_tx_mode_if.sv
// Link-layer to soft TX PCS bundle: octets, K flags, per-lane controls in; encoded lane words and running disparity out.
// The master side is the link layer; the slave side is the PCS.
interface jesd204_soft_pcs_tx_mode_if #(
    parameter int NUM_LANES       = 1,
    parameter int DATA_PATH_WIDTH = 4,
    parameter int IFC_TYPE        = 0
);
    localparam int LANE_W = DATA_PATH_WIDTH*10 + IFC_TYPE*40;

    logic [NUM_LANES*DATA_PATH_WIDTH*8-1:0] char;
    logic [NUM_LANES*DATA_PATH_WIDTH-1:0]   charisk;
    logic [NUM_LANES-1:0]                   lane_enable;
    logic [NUM_LANES-1:0]                   invert;
    logic [1:0]                             test_mode;
    logic [NUM_LANES*LANE_W-1:0]            data;
    logic [NUM_LANES-1:0]                   disparity;

    modport master (
        output char, charisk, lane_enable, invert, test_mode,
        input  data, disparity
    );

    modport slave (
        input  char, charisk, lane_enable, invert, test_mode,
        output data, disparity
    );
endinterface

// File: rtl/jesd204_soft_pcs_tx_mode.sv
// Multi-lane soft 8b10b JESD204B TX PCS with lane enable, runtime inversion and K28.5/D21.5/PRBS7 test patterns.
// Fixed 2-cycle latency, no backpressure; PRBS7 is built only when JESD204_SOFT_PCS_TX_PRBS_EN is defined.
module jesd204_8b10b_encoder (
    input  logic [7:0] in_char,
    input  logic       in_charisk,
    input  logic       in_disparity,
    output logic [9:0] out_char,
    output logic       out_disparity
);
    logic [4:0] x;
    logic [2:0] y;
    logic [5:0] t6, c6;
    logic [3:0] t4, c4;
    logic       unbal6, rd6, alt7, comp4;

    assign x = in_char[4:0];
    assign y = in_char[7:5];

    // Tables hold the RD- code with bit 'a' (resp. 'f') in the MSB.
    always_comb begin
        case (x)
            5'd0:  t6 = 6'b100111;  5'd1:  t6 = 6'b011101;
            5'd2:  t6 = 6'b101101;  5'd3:  t6 = 6'b110001;
            5'd4:  t6 = 6'b110101;  5'd5:  t6 = 6'b101001;
            5'd6:  t6 = 6'b011001;  5'd7:  t6 = 6'b111000;
            5'd8:  t6 = 6'b111001;  5'd9:  t6 = 6'b100101;
            5'd10: t6 = 6'b010101;  5'd11: t6 = 6'b110100;
            5'd12: t6 = 6'b001101;  5'd13: t6 = 6'b101100;
            5'd14: t6 = 6'b011100;  5'd15: t6 = 6'b010111;
            5'd16: t6 = 6'b011011;  5'd17: t6 = 6'b100011;
            5'd18: t6 = 6'b010011;  5'd19: t6 = 6'b110010;
            5'd20: t6 = 6'b001011;  5'd21: t6 = 6'b101010;
            5'd22: t6 = 6'b011010;  5'd23: t6 = 6'b111010;
            5'd24: t6 = 6'b110011;  5'd25: t6 = 6'b100110;
            5'd26: t6 = 6'b010110;  5'd27: t6 = 6'b110110;
            5'd28: t6 = 6'b001110;  5'd29: t6 = 6'b101110;
            5'd30: t6 = 6'b011110;  default: t6 = 6'b101011;
        endcase
        if (in_charisk && x == 5'd28) begin
            t6 = 6'b001111;
        end
        unbal6 = ($countones(t6) != 3);
        c6     = t6 ^ {6{in_disparity & (unbal6 | (x == 5'd7))}};
        rd6    = in_disparity ^ unbal6;

        alt7 = in_charisk
             | (~rd6 & ((x == 5'd17) | (x == 5'd18) | (x == 5'd20)))
             | ( rd6 & ((x == 5'd11) | (x == 5'd13) | (x == 5'd14)));
        case (y)
            3'd0:    t4 = 4'b1011;
            3'd1:    t4 = 4'b1001;
            3'd2:    t4 = 4'b0101;
            3'd3:    t4 = 4'b1100;
            3'd4:    t4 = 4'b1101;
            3'd5:    t4 = 4'b1010;
            3'd6:    t4 = 4'b0110;
            default: t4 = alt7 ? 4'b0111 : 4'b1110;
        endcase
        // Balanced K.x.1/2/5/6 codes flip polarity relative to their D counterparts.
        if (y == 3'd1 || y == 3'd2 || y == 3'd5 || y == 3'd6) begin
            comp4 = in_charisk & ~rd6;
        end else begin
            comp4 = rd6;
        end
        c4 = t4 ^ {4{comp4}};

        out_disparity = rd6 ^ ((y == 3'd0) | (y == 3'd4) | (y == 3'd7));
        out_char = {c4[0], c4[1], c4[2], c4[3], c6[0], c6[1], c6[2], c6[3], c6[4], c6[5]};
    end
endmodule

module jesd204_soft_pcs_tx_mode #(
    parameter int                   NUM_LANES       = 1,
    parameter int                   DATA_PATH_WIDTH = 4,
    parameter int                   IFC_TYPE        = 0,
    parameter logic [NUM_LANES-1:0] INVERT_MASK     = '0
) (
    input logic                        clk,
    input logic                        reset,
    jesd204_soft_pcs_tx_mode_if.slave  tx
);
    localparam int DPW = DATA_PATH_WIDTH;
    localparam int SW  = DPW*10;
    localparam int LW  = SW + IFC_TYPE*40;

    logic [NUM_LANES*DPW*8-1:0] src_char, s1_char;
    logic [NUM_LANES*DPW-1:0]   src_k, s1_k;
    logic [NUM_LANES-1:0]       s1_en, s1_inv;
    logic                       s1_vld;
    logic [NUM_LANES*LW-1:0]    data_next, data_q;
    logic [NUM_LANES-1:0]       disp_next, disp_q;

`ifdef JESD204_SOFT_PCS_TX_PRBS_EN
    logic [6:0]       lfsr, lfsr_next;
    logic [DPW*8-1:0] prbs_bits;

    // x^7+x^6+1, first generated bit lands in the LSB of octet 0.
    always_comb begin
        logic fb;
        lfsr_next = lfsr;
        prbs_bits = '0;
        for (int i = 0; i < DPW*8; i++) begin
            fb           = lfsr_next[6] ^ lfsr_next[5];
            prbs_bits[i] = fb;
            lfsr_next    = {lfsr_next[5:0], fb};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            lfsr <= 7'h7F;
        end else if (tx.test_mode == 2'b11) begin
            lfsr <= lfsr_next;
        end
    end
`endif

    always_comb begin
        src_char = tx.char;
        src_k    = tx.charisk;
        case (tx.test_mode)
            2'b01: begin
                src_char = {NUM_LANES*DPW{8'hBC}};
                src_k    = '1;
            end
            2'b10: begin
                src_char = {NUM_LANES*DPW{8'hB5}};
                src_k    = '0;
            end
`ifdef JESD204_SOFT_PCS_TX_PRBS_EN
            2'b11: begin
                src_char = {NUM_LANES{prbs_bits}};
                src_k    = '0;
            end
`endif
            default: ;
        endcase
        for (int l = 0; l < NUM_LANES; l++) begin
            if (!tx.lane_enable[l]) begin
                src_char[l*DPW*8 +: DPW*8] = '0;
                src_k[l*DPW +: DPW]        = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_char <= '0;
            s1_k    <= '0;
            s1_en   <= '0;
            s1_inv  <= '0;
            s1_vld  <= 1'b0;
        end else begin
            s1_char <= src_char;
            s1_k    <= src_k;
            s1_en   <= tx.lane_enable;
            s1_inv  <= tx.invert ^ INVERT_MASK;
            s1_vld  <= 1'b1;
        end
    end

    for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
        logic [SW-1:0] lane_sym;
        logic [SW-1:0] word;

        for (genvar i = 0; i < DPW; i++) begin : g_oct
            logic       rd_in, rd_out;
            logic [9:0] sym;
            if (i == 0) begin : g_first
                assign rd_in = disp_q[l];
            end else begin : g_next
                assign rd_in = g_oct[i-1].rd_out;
            end
            jesd204_8b10b_encoder u_enc (
                .in_char       (s1_char[(l*DPW+i)*8 +: 8]),
                .in_charisk    (s1_k[l*DPW+i]),
                .in_disparity  (rd_in),
                .out_char      (sym),
                .out_disparity (rd_out)
            );
            assign lane_sym[i*10 +: 10] = sym;
        end

        // A disabled lane emits zeros and parks at RD- so re-enable starts clean.
        assign word         = (s1_en[l] ? lane_sym : {SW{1'b0}}) ^ {SW{s1_inv[l]}};
        assign disp_next[l] = s1_vld & s1_en[l] & g_oct[DPW-1].rd_out;

        if (IFC_TYPE == 1) begin : g_pad
            assign data_next[l*LW +: LW] = s1_vld ?
                {1'b1, 19'b0, word[SW-1:20], 1'b0, 1'b1, 18'b0, word[19:0]} : {LW{1'b0}};
        end else begin : g_raw
            assign data_next[l*LW +: LW] = word;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            data_q <= '0;
            disp_q <= '0;
        end else begin
            data_q <= data_next;
            disp_q <= disp_next;
        end
    end

    assign tx.data      = data_q;
    assign tx.disparity = disp_q;
endmodule

// File: tb/tb_jesd204_soft_pcs_tx_mode.sv
// Scoreboard bench: a 4-lane packed-symbol PCS and a 1-lane F-Tile padded PCS fed the lane-0 stream in parallel.
module tb_jesd204_soft_pcs_tx_mode;
    localparam logic [3:0]  MASK = 4'b1000;
    localparam logic [31:0] LA = 32'hBCBCBCBC, LB = 32'h07F12000;
    localparam logic [31:0] LC = 32'h2000BC1C, LD = 32'h0707F1F1;
    localparam logic [3:0]  KA = 4'hF, KB = 4'h0, KC = 4'b0011, KD = 4'h0;

    typedef struct {
        logic [159:0] d;
        logic [3:0]   r;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    bit   issue = 1'b0;
    logic [1:0] vld_pipe = 2'b00;
    logic [3:0] exp_rd = 4'h0;
    exp_t q[$];
    int n_chk = 0;
    int n_fail = 0;

    jesd204_soft_pcs_tx_mode_if #(.NUM_LANES(4), .DATA_PATH_WIDTH(4), .IFC_TYPE(0)) ifa ();
    jesd204_soft_pcs_tx_mode_if #(.NUM_LANES(1), .DATA_PATH_WIDTH(4), .IFC_TYPE(1)) ifb ();

    jesd204_soft_pcs_tx_mode #(.NUM_LANES(4), .DATA_PATH_WIDTH(4), .IFC_TYPE(0), .INVERT_MASK(MASK)) dut_a (
        .clk(clk), .reset(reset), .tx(ifa));
    jesd204_soft_pcs_tx_mode #(.NUM_LANES(1), .DATA_PATH_WIDTH(4), .IFC_TYPE(1), .INVERT_MASK(1'b0)) dut_b (
        .clk(clk), .reset(reset), .tx(ifb));

    assign ifb.char        = ifa.char[31:0];
    assign ifb.charisk     = ifa.charisk[3:0];
    assign ifb.lane_enable = ifa.lane_enable[0];
    assign ifb.invert      = ifa.invert[0];
    assign ifb.test_mode   = ifa.test_mode;

    always #5 clk = ~clk;

    always @(posedge clk) vld_pipe <= {vld_pipe[0], issue};

    // Standard 8b10b codes (bit 0 = 'a') for the characters used below: {RD- code, RD+ code}.
    function automatic logic [9:0] ref_code(input logic [7:0] o, input logic k, input logic rd);
        logic [9:0] m, p;
        case ({k, o})
            9'h1BC:  begin m = 10'h17C; p = 10'h283; end
            9'h11C:  begin m = 10'h0BC; p = 10'h343; end
            9'h000:  begin m = 10'h0B9; p = 10'h346; end
            9'h020:  begin m = 10'h279; p = 10'h246; end
            9'h0F1:  begin m = 10'h3B1; p = 10'h231; end
            9'h007:  begin m = 10'h347; p = 10'h0B8; end
            9'h0B5:  begin m = 10'h155; p = 10'h155; end
            default: begin m = 10'h3FF; p = 10'h3FF; end
        endcase
        return rd ? p : m;
    endfunction

    task automatic check(input string name, input logic [159:0] act, input logic [159:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    // Drive one word at the current falling edge, model it, then advance to the next falling edge.
    task automatic step(input logic [127:0] ch, input logic [15:0] kk, input logic [3:0] en,
                        input logic [3:0] inv, input logic [1:0] mode, input bit chk);
        exp_t e;
        logic [39:0] w;
        logic [9:0]  c;
        logic [7:0]  o;
        logic        k1;
        ifa.char        = ch;
        ifa.charisk     = kk;
        ifa.lane_enable = en;
        ifa.invert      = inv;
        ifa.test_mode   = mode;
        issue           = chk;
        for (int l = 0; l < 4; l++) begin
            w = '0;
            if (en[l]) begin
                for (int i = 0; i < 4; i++) begin
                    case (mode)
                        2'b01:   begin o = 8'hBC; k1 = 1'b1; end
                        2'b10:   begin o = 8'hB5; k1 = 1'b0; end
                        default: begin o = ch[(l*4+i)*8 +: 8]; k1 = kk[l*4+i]; end
                    endcase
                    c = ref_code(o, k1, exp_rd[l]);
                    w[i*10 +: 10] = c;
                    if ($countones(c) != 5) exp_rd[l] = ~exp_rd[l];
                end
            end else begin
                exp_rd[l] = 1'b0;
            end
            w = w ^ {40{inv[l] ^ MASK[l]}};
            e.d[l*40 +: 40] = w;
            e.r[l] = exp_rd[l];
        end
        if (chk) q.push_back(e);
        @(negedge clk);
    endtask

    initial begin
        exp_t e;
        logic [79:0] pk;
        forever begin
            @(negedge clk);
            if (vld_pipe[1]) begin
                if (q.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL scoreboard: output word arrived with 0 expected entries, required 1");
                end else begin
                    e  = q.pop_front();
                    pk = {1'b1, 19'b0, e.d[39:20], 1'b0, 1'b1, 18'b0, e.d[19:0]};
                    check("a_data", ifa.data, e.d);
                    check("a_disparity", {156'b0, ifa.disparity}, {156'b0, e.r});
                    check("b_data", {80'b0, ifb.data}, {80'b0, pk});
                    check("b_disparity", {159'b0, ifb.disparity}, {159'b0, e.r[0]});
                end
            end
        end
    end

    initial begin
        ifa.char = '0; ifa.charisk = '0; ifa.lane_enable = '0; ifa.invert = '0; ifa.test_mode = 2'b00;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_a_data", ifa.data, 160'b0);
        check("reset_a_disp", {156'b0, ifa.disparity}, 160'b0);
        check("reset_b_data", {80'b0, ifb.data}, 160'b0);
        check("reset_b_disp", {159'b0, ifb.disparity}, 160'b0);
        reset = 1'b0;
        exp_rd = 4'h0;

        repeat (3) step('0, '0, 4'hF, 4'h0, 2'b01, 1);
        repeat (2) step('0, '0, 4'hF, 4'h0, 2'b10, 1);
        step('0, '0, 4'hF, 4'b0001, 2'b10, 1);
        step('0, '0, 4'hF, 4'b1001, 2'b10, 1);

        step({LD, LC, LB, LA}, {KD, KC, KB, KA}, 4'hF, 4'h0, 2'b00, 1);
        step({LA, LB, LC, LD}, {KA, KB, KC, KD}, 4'hF, 4'b0110, 2'b00, 1);
        step({LB, LD, LA, LC}, {KB, KD, KA, KC}, 4'hF, 4'h0, 2'b00, 1);
        step('0, '0, 4'hF, 4'h0, 2'b01, 1);
        step({LC, LA, LD, LB}, {KC, KA, KD, KB}, 4'hF, 4'h0, 2'b00, 1);

        step({LD, LB, LC, LA}, {KD, KB, KC, KA}, 4'hF, 4'h0, 2'b00, 1);
        repeat (5) step({LD, LB, LC, LA}, {KD, KB, KC, KA}, 4'b1011, 4'h0, 2'b00, 1);
        repeat (2) step({LD, LB, LC, LA}, {KD, KB, KC, KA}, 4'hF, 4'h0, 2'b00, 1);
        step({LD, LB, LC, LA}, {KD, KB, KC, KA}, 4'b0111, 4'h0, 2'b00, 1);
        step({LD, LB, LC, LA}, {KD, KB, KC, KA}, 4'hF, 4'h0, 2'b00, 1);
`ifndef JESD204_SOFT_PCS_TX_PRBS_EN
        step({LB, LA, LD, LC}, {KB, KA, KD, KC}, 4'hF, 4'h0, 2'b11, 1);
        step({LD, LC, LB, LA}, {KD, KC, KB, KA}, 4'hF, 4'b0010, 2'b11, 1);
`endif

        repeat (2) step({LB, LC, LD, LB}, {KB, KC, KD, KB}, 4'hF, 4'h0, 2'b00, 0);
        reset = 1'b1;
        issue = 1'b0;
        @(negedge clk);
        check("midreset_a_data", ifa.data, 160'b0);
        check("midreset_a_disp", {156'b0, ifa.disparity}, 160'b0);
        check("midreset_b_data", {80'b0, ifb.data}, 160'b0);
        reset = 1'b0;
        exp_rd = 4'h0;
        step({LB, LB, LB, LB}, {KB, KB, KB, KB}, 4'hF, 4'h0, 2'b00, 1);
        check("refill_a_data", ifa.data, 160'b0);
        check("refill_b_data", {80'b0, ifb.data}, 160'b0);
        step({LB, LB, LB, LB}, {KB, KB, KB, KB}, 4'hF, 4'h0, 2'b00, 1);
        step('0, '0, 4'hF, 4'h0, 2'b01, 1);
        repeat (3) step('0, '0, 4'hF, 4'h0, 2'b10, 0);

        n_chk++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: %0d entries left, required 0", q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        n_fail++;
        $display("FAIL timeout: simulation still running at %0t, required completion", $time);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $fatal(1, "timeout");
    end
endmodule
